mdu_unit: RTL and testbench

//  Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers; sits in EX beside the ALU.

---
 rtl/mdu_unit_if.sv | 26 ++
 rtl/mdu_unit.sv | 137 +++++++++++++
 tb/tb_mdu_unit.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_unit_if.sv
// mdu_unit_if: issue/result bundle between the EX stage and the multiply/divide unit.
//   start, op, a, b, cancel : issue side, driven by the pipeline (master)
//   busy, stall_req, hi, lo : status and architectural HI/LO, driven by the unit (slave)
interface mdu_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             busy;
    logic             stall_req;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, cancel,
        input  busy, stall_req, hi, lo
    );

    modport slave (
        input  start, op, a, b, cancel,
        output busy, stall_req, hi, lo
    );
endinterface

// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit with architectural HI/LO registers.
//   Ops: 0 mult, 1 multu, 2 div, 3 divu, 4 madd, 5 maddu, 6 mthi, 7 mtlo.
//   mthi/mtlo write in one cycle; the others capture operands and the current
//   HI/LO at accept, stay busy for MULT_CYCLES or DIV_CYCLES cycles, then write
//   HI/LO and drop busy on the same edge.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high; clears busy, counter, HI and LO
//   bus.start  issue request            bus.op      operation code
//   bus.a      rs operand               bus.b       rt operand
//   bus.cancel squashes a same-cycle start
//   bus.busy   multi-cycle op in flight (registered)
//   bus.stall_req  busy or accepting a multi-cycle op (combinational)
//   bus.hi / bus.lo  architectural HI / LO (registered)
module mdu_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic       clk,
    input logic       reset,
    mdu_unit_if.slave bus
);
    localparam int MAXN = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXN + 1);

    localparam logic [2:0] OP_MTHI = 3'd6;

    // Sign- or zero-extend both operands to 2*WIDTH; the low 2*WIDTH bits of the
    // product are then correct for both signednesses. Accumulate wraps modulo 2^(2W).
    function automatic logic [2*WIDTH-1:0] mul_acc(
        input logic               sgn,
        input logic               acc_en,
        input logic [WIDTH-1:0]   x,
        input logic [WIDTH-1:0]   y,
        input logic [2*WIDTH-1:0] acc
    );
        logic [2*WIDTH-1:0] xe;
        logic [2*WIDTH-1:0] ye;
        logic [2*WIDTH-1:0] prod;
        xe   = sgn ? {{WIDTH{x[WIDTH-1]}}, x} : {{WIDTH{1'b0}}, x};
        ye   = sgn ? {{WIDTH{y[WIDTH-1]}}, y} : {{WIDTH{1'b0}}, y};
        prod = xe * ye;
        return acc_en ? (prod + acc) : prod;
    endfunction

    // Returns {remainder, quotient}. Divide by zero yields quotient all ones and
    // remainder = dividend; the signed MIN / -1 overflow yields quotient MIN, remainder 0.
    function automatic logic [2*WIDTH-1:0] div_rem(
        input logic             sgn,
        input logic [WIDTH-1:0] n,
        input logic [WIDTH-1:0] d
    );
        logic signed [WIDTH-1:0] sq;
        logic signed [WIDTH-1:0] sr;
        if (d == '0) begin
            return {n, {WIDTH{1'b1}}};
        end else if (sgn && (n == {1'b1, {(WIDTH-1){1'b0}}}) && (d == {WIDTH{1'b1}})) begin
            return {{WIDTH{1'b0}}, n};
        end else if (sgn) begin
            sq = $signed(n) / $signed(d);
            sr = $signed(n) % $signed(d);
            return {sr, sq};
        end else begin
            return {n % d, n / d};
        end
    endfunction

    logic                 vld_p1;
    logic [CW-1:0]        cnt_p1;
    logic [2:0]           op_p1;
    logic [WIDTH-1:0]     a_p1;
    logic [WIDTH-1:0]     b_p1;
    logic [2*WIDTH-1:0]   acc_p1;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic [2*WIDTH-1:0]   result;

    logic accept;
    logic is_multi;
    logic is_div;

    assign is_multi = ~(bus.op[2] & bus.op[1]);
    assign is_div   = (bus.op[2:1] == 2'b01);
    assign accept   = bus.start & ~bus.cancel & ~vld_p1;

    // Issue -> p1: capture operands and current HI/LO for the multi-cycle op
    always_ff @(posedge clk) begin
        if (accept && is_multi) begin
            op_p1  <= bus.op;
            a_p1   <= bus.a;
            b_p1   <= bus.b;
            acc_p1 <= {hi_q, lo_q};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            cnt_p1 <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else if (accept && is_multi) begin
            vld_p1 <= 1'b1;
            cnt_p1 <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end else if (accept) begin
            if (bus.op == OP_MTHI) begin
                hi_q <= bus.a;
            end else begin
                lo_q <= bus.a;
            end
        end else if (vld_p1) begin
            cnt_p1 <= cnt_p1 - CW'(1);
            // Count of 1 marks the last busy cycle: commit and release together.
            if (cnt_p1 == CW'(1)) begin
                vld_p1 <= 1'b0;
                hi_q   <= result[2*WIDTH-1:WIDTH];
                lo_q   <= result[WIDTH-1:0];
            end
        end
    end

    // p1 -> commit: result is formed from the captured operands only
    always_comb begin
        result = '0;
        if (op_p1[2:1] == 2'b01) begin
            result = div_rem(~op_p1[0], a_p1, b_p1);
        end else begin
            result = mul_acc(~op_p1[0], op_p1[2], a_p1, b_p1, acc_p1);
        end
    end

    assign bus.busy      = vld_p1;
    assign bus.stall_req = vld_p1 | (bus.start & ~bus.cancel & is_multi);
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
endmodule

// File: tb/tb_mdu_unit.sv
// Bench for mdu_unit: directed vectors with literal expectations, plus a
// behavioural model compared against busy/stall_req/hi/lo on every cycle.
module tb_mdu_unit;
    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mdu_unit_if #(.WIDTH(W)) bus();

    mdu_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_hi, m_lo;
    logic        m_busy;
    logic [63:0] pend;
    logic        acc_ok;
    logic        cmp_en = 1'b0;
    int          cyc = 0;
    int          commit_at = 0;

    function automatic logic [63:0] model_result(input logic [2:0] op, input logic [31:0] a,
                                                 input logic [31:0] b, input logic [63:0] acc);
        int          ia, ib;
        longint      la, lb, ua, ub, q, rm;
        logic [63:0] r;
        ia = a;
        ib = b;
        la = ia;
        lb = ib;
        r  = '0;
        case (op)
            3'd0, 3'd4: r = la * lb;
            3'd1, 3'd5: r = {32'b0, a} * {32'b0, b};
            3'd2: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else begin
                    ua = (la < 0) ? -la : la;
                    ub = (lb < 0) ? -lb : lb;
                    q  = ua / ub;
                    if ((la < 0) != (lb < 0)) q = -q;
                    rm = la - q * lb;
                    r  = {rm[31:0], q[31:0]};
                end
            end
            3'd3: r = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: r = '0;
        endcase
        if (op == 3'd4 || op == 3'd5) r = r + acc;
        return r;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_hi   = '0;
            m_lo   = '0;
            m_busy = 1'b0;
        end else begin
            acc_ok = bus.start && !bus.cancel && !m_busy;
            if (m_busy && cyc == commit_at) begin
                {m_hi, m_lo} = pend;
                m_busy = 1'b0;
            end
            if (acc_ok) begin
                if (bus.op == 3'd6) m_hi = bus.a;
                else if (bus.op == 3'd7) m_lo = bus.a;
                else begin
                    pend      = model_result(bus.op, bus.a, bus.b, {m_hi, m_lo});
                    m_busy    = 1'b1;
                    commit_at = cyc + ((bus.op == 3'd2 || bus.op == 3'd3) ? DC : MC);
                end
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc busy", bus.busy, m_busy);
            check("cyc stall_req", bus.stall_req,
                  m_busy | (bus.start & ~bus.cancel & (bus.op <= 3'd5)));
            check("cyc hi", bus.hi, m_hi);
            check("cyc lo", bus.lo, m_lo);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic c);
        bus.start  = 1'b1;
        bus.op     = op;
        bus.a      = a;
        bus.b      = b;
        bus.cancel = c;
    endtask

    task automatic idle();
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n, input logic [63:0] exp);
        drive(op, a, b, 1'b0);
        step();
        idle();
        for (int k = 1; k <= n; k++) begin
            check({name, " busy"}, bus.busy, 1'b1);
            step();
        end
        check({name, " busy end"}, bus.busy, 1'b0);
        check({name, " hilo"}, {bus.hi, bus.lo}, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        bus.op     = 3'd0;
        bus.a      = '0;
        bus.b      = '0;
        reset      = 1'b1;
        step();
        step();
        cmp_en = 1'b1;
        reset  = 1'b0;
        check("reset busy", bus.busy, 1'b0);
        check("reset hilo", {bus.hi, bus.lo}, 64'h0);

        run_op("mult",  3'd0, 32'hFFFF_FFFE, 32'd3, MC, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op("multu", 3'd1, 32'hFFFF_FFFE, 32'd3, MC, 64'h0000_0002_FFFF_FFFA);
        run_op("div",   3'd2, -32'sd7, 32'd2, DC, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu0", 3'd3, 32'd7, 32'd0, DC, 64'h0000_0007_FFFF_FFFF);
        run_op("divneg", 3'd2, 32'd7, -32'sd2, DC, 64'h0000_0001_FFFF_FFFD);
        run_op("divovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, DC, 64'h0000_0000_8000_0000);

        // mthi / mtlo then madd
        drive(3'd6, 32'd1, 32'd0, 1'b0);
        #1;
        check("mthi stall", bus.stall_req, 1'b0);
        step();
        drive(3'd7, 32'd0, 32'd0, 1'b0);
        step();
        idle();
        check("mt busy", bus.busy, 1'b0);
        check("mt hilo", {bus.hi, bus.lo}, 64'h0000_0001_0000_0000);
        run_op("madd", 3'd4, 32'h8000_0000, 32'h8000_0000, MC, 64'h4000_0001_0000_0000);

        // cancel squashes the start
        drive(3'd0, 32'd3, 32'd3, 1'b1);
        #1;
        check("cancel stall", bus.stall_req, 1'b0);
        step();
        idle();
        check("cancel busy", bus.busy, 1'b0);
        check("cancel hilo", {bus.hi, bus.lo}, 64'h4000_0001_0000_0000);

        // start while busy is ignored
        drive(3'd0, 32'd2, 32'd3, 1'b0);
        step();
        idle();
        step();
        drive(3'd3, 32'd100, 32'd7, 1'b0);
        step();
        idle();
        for (int k = 3; k <= MC; k++) begin
            check("ign busy", bus.busy, 1'b1);
            step();
        end
        check("ign busy end", bus.busy, 1'b0);
        check("ign hilo", {bus.hi, bus.lo}, 64'h0000_0000_0000_0006);
        step();
        check("ign no start", bus.busy, 1'b0);

        // back-to-back: div issued the cycle busy falls
        drive(3'd0, 32'd5, 32'd6, 1'b0);
        step();
        idle();
        for (int k = 1; k <= MC; k++) begin
            check("b2b stall1", bus.stall_req, 1'b1);
            step();
        end
        check("b2b mult hilo", {bus.hi, bus.lo}, 64'd30);
        drive(3'd2, -32'sd100, 32'd7, 1'b0);
        #1;
        check("b2b stall gap", bus.stall_req, 1'b1);
        step();
        idle();
        for (int k = 1; k <= DC; k++) begin
            check("b2b stall2", bus.stall_req, 1'b1);
            step();
        end
        check("b2b busy end", bus.busy, 1'b0);
        check("b2b div hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFE_FFFF_FFF2);

        // reset mid-div
        drive(3'd2, 32'd100, 32'd7, 1'b0);
        step();
        idle();
        repeat (3) step();
        check("rst mid busy", bus.busy, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst mid busy0", bus.busy, 1'b0);
        check("rst mid hilo", {bus.hi, bus.lo}, 64'h0);
        repeat (12) step();
        check("rst no commit busy", bus.busy, 1'b0);
        check("rst no commit hilo", {bus.hi, bus.lo}, 64'h0);

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
